// File: rtl/dsr_train_tx.sv
// Serializer-side link bring-up: trains the OSERDES word until the far end aligns, then forwards user data.
// Outputs are registered from the next state (1-cycle latency); no backpressure, valid words pass straight through in Data.
module dsr_train_tx #(
  parameter int            DW         = 12,
  parameter logic [DW-1:0] TRAIN_PAT  = 12'h03F,
  parameter int            RST_CYC    = 7,
  parameter int            SETTLE_CYC = 16,
  parameter int            TIMEOUT    = 1023,
  parameter int            MAX_RETRY  = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          RETRAIN,
  input  logic          RX_ALIGNED,
  input  logic [DW-1:0] DATA_IN,
  input  logic          DATA_VLD,
  output logic          SER_RST,
  output logic [DW-1:0] TX_WORD,
  output logic          TRAINING,
  output logic          LINK_UP,
  output logic          TIMEOUT_ERR,
  output logic [1:0]    RETRY_CNT
);

  localparam int CW = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERRST = 3'd1,
    S_TRAIN  = 3'd2,
    S_SETTLE = 3'd3,
    S_DATA   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    retry_nxt;
  logic [1:0]    retry_inc;

  assign retry_inc = RETRY_CNT + 2'd1;

  always_comb begin
    nxt       = state;
    retry_nxt = RETRY_CNT;
    case (state)
      S_IDLE: begin
        if (START) begin
          nxt       = S_SERRST;
          retry_nxt = '0;
        end
      end
      S_SERRST: begin
        if (cnt == CW'(RST_CYC - 1)) nxt = S_TRAIN;
      end
      S_TRAIN: begin
        // Alignment beats a timeout landing on the same cycle.
        if (RX_ALIGNED) begin
          nxt = S_SETTLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          retry_nxt = retry_inc;
          nxt       = (retry_inc == 2'(MAX_RETRY)) ? S_FAIL : S_SERRST;
        end
      end
      S_SETTLE: begin
        // Settle lasts SETTLE_CYC aligned cycles; any drop restarts the Train timeout.
        if (!RX_ALIGNED) nxt = S_TRAIN;
        else if (cnt == CW'(SETTLE_CYC - 1)) nxt = S_DATA;
      end
      S_DATA: begin
        if (RETRAIN || !RX_ALIGNED) begin
          nxt       = S_SERRST;
          retry_nxt = '0;
        end
      end
      S_FAIL: begin
        if (START) begin
          nxt       = S_SERRST;
          retry_nxt = '0;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      SER_RST     <= 1'b0;
      TX_WORD     <= '0;
      TRAINING    <= 1'b0;
      LINK_UP     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      RETRY_CNT   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        cnt <= '0;
      end else if (state == S_SERRST || state == S_TRAIN || state == S_SETTLE) begin
        cnt <= cnt + CW'(1);
      end

      SER_RST     <= (nxt == S_SERRST);
      TRAINING    <= (nxt == S_TRAIN) || (nxt == S_SETTLE);
      LINK_UP     <= (nxt == S_DATA);
      TIMEOUT_ERR <= (nxt == S_FAIL);
      RETRY_CNT   <= retry_nxt;

      case (nxt)
        S_TRAIN, S_SETTLE: TX_WORD <= TRAIN_PAT;
        S_DATA:            TX_WORD <= DATA_VLD ? DATA_IN : TRAIN_PAT;
        default:           TX_WORD <= '0;
      endcase
    end
  end

endmodule
